// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame constants and baud divisor helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit, rounded to nearest.
  function automatic int baud_div(input int input_clock, input int baud_rate);
    return (input_clock + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead read data and count-derived flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_wr;
  logic             do_rd;

  // Flags come from the registered count, so a write never reaches full combinationally.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter with internal baud counter
// Optional even parity (8E1) when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK = 27000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);

  localparam int DIV   = baud_div(INPUT_CLOCK, BAUD_RATE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);

  uart_state_t          state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 tx_q, tx_n;
  logic                 overflow_q;
  logic                 pop;
  logic                 bit_done;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      shift_q    <= shift_n;
      idx_q      <= idx_n;
      tx_q       <= tx_n;
      overflow_q <= overflow_q | (wr_en & full);
`ifdef UART_TX_PARITY_EN
      par_q      <= par_n;
`endif
    end
  end

  // tx_n is the line level for the bit that starts on the coming edge.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    shift_n  = shift_q;
    idx_n    = idx_q;
    tx_n     = tx_q;
    pop      = 1'b0;
    bit_done = (cnt_q == '0);
`ifdef UART_TX_PARITY_EN
    par_n    = par_q;
`endif
    if (state_q != ST_IDLE) cnt_n = bit_done ? CNT_LOAD : cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_data;
          cnt_n   = CNT_LOAD;
          tx_n    = 1'b0;
          state_n = ST_START;
`ifdef UART_TX_PARITY_EN
          par_n   = ^fifo_data;
`endif
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_n = ST_DATA;
          idx_n   = '0;
          tx_n    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
            tx_n    = par_q;
`else
            state_n = ST_STOP;
            idx_n   = '0;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n   = idx_q + 1'b1;
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          state_n = ST_STOP;
          idx_n   = '0;
          tx_n    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            // Back-to-back frames: pop straight into the next start bit.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_n = fifo_data;
              cnt_n   = CNT_LOAD;
              tx_n    = 1'b0;
              state_n = ST_START;
`ifdef UART_TX_PARITY_EN
              par_n   = ^fifo_data;
`endif
            end else begin
              state_n = ST_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign empty    = fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - randomized self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  localparam int DIV   = 10;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full, empty, overflow, busy, tx;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue contents plus timing of the frame on the line.
  logic [7:0] q[$];
  bit         m_idle = 1'b1;
  bit         m_ovf  = 1'b0;
  int         t      = 0;
  int         f_start = 0;
  int         f_end   = 0;
  logic [7:0] cur    = 8'h00;
  logic [7:0] rx_byte = 8'h00;

  uart_tx_buffered #(
    .INPUT_CLOCK (1000000),
    .BAUD_RATE   (100000),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int n;
    n = k / DIV;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
`ifdef UART_TX_PARITY_EN
    if (n == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_edge(input bit we, input logic [7:0] d);
    bit full_b;
    bit do_pop;
    t++;
    full_b = (q.size() == DEPTH);
    do_pop = (q.size() > 0) && (m_idle || t == f_end);
    if (!do_pop && !m_idle && t == f_end) m_idle = 1'b1;
    if (we) begin
      if (full_b) m_ovf = 1'b1;
      else q.push_back(d);
    end
    if (do_pop) begin
      cur     = q.pop_front();
      f_start = t;
      f_end   = t + FB * DIV;
      m_idle  = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic exp_tx;
    int   k;
    exp_tx = m_idle ? 1'b1 : exp_bit(cur, t - f_start);
    check("tx", 32'(tx), 32'(exp_tx));
    check("busy", 32'(busy), 32'(!m_idle));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (!m_idle) begin
      k = t - f_start;
      if (k % DIV == DIV / 2 && k / DIV >= 1 && k / DIV <= 8) rx_byte[k/DIV-1] = tx;
      if (k == FB * DIV - 1) check("rx_byte", 32'(rx_byte), 32'(cur));
    end
  endtask

  task automatic step(input bit we, input logic [7:0] d);
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    model_edge(we, d);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_full", 32'(full), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    wr_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    m_idle = 1'b1;
    m_ovf  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((!m_idle || q.size() > 0) && n < 5000) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("drain_done", 32'(m_idle && q.size() == 0), 32'(1));
  endtask

  initial begin
    int n;
    int dens;
    // Power-up reset
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_outputs();

    // Idle after reset
    for (int i = 0; i < 200; i++) step(1'b0, 8'h00);

    // Single byte
    step(1'b1, 8'h55);
    drain();

    // Two back-to-back bytes
    step(1'b1, 8'hA3);
    step(1'b1, 8'h0F);
    drain();

    // Overflow: 18 consecutive writes while idle
    for (int i = 0; i < 18; i++) step(1'b1, 8'(i));
    check("t4_full", 32'(full), 32'(1));
    check("t4_overflow", 32'(overflow), 32'(1));
    drain();
    do_reset();

    // Reset during data bit 3 of 0xFF with 3 bytes queued
    step(1'b1, 8'hFF);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    n = 0;
    while (!(!m_idle && cur == 8'hFF && (t - f_start) == 4 * DIV + 3) && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("t5_reached_bit3", 32'(n < 200), 32'(1));
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b0, 8'h00);

`ifdef UART_TX_PARITY_EN
    step(1'b1, 8'h07);
    drain();
    step(1'b1, 8'h03);
    drain();
`endif

    // Randomized traffic at several write densities
    for (int ph = 0; ph < 4; ph++) begin
      dens = (ph == 0) ? 5 : (ph == 1) ? 30 : (ph == 2) ? 70 : 95;
      for (int i = 0; i < 600; i++) step(bit'($urandom_range(0, 99) < dens), 8'($urandom));
      drain();
      if (ph == 2) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
